asteroid_mover: RTL and testbench
=================================

# asteroid_mover

Moves one asteroid sprite down the 160x120 VGA playfield, one pixel row per frame. Draws the sprite, waits one frame, erases it, steps it down, and redraws. When the sprite rests on the ground it raises `asteroid_move_done`, which feeds the asteroid/ground collision stage directly downstream. A rocket hit removes the asteroid early, and `asteroid_move_done` stays low in that case.

## Interface
- `SIZE`, 4: sprite edge length in pixels; the sprite is square and SIZE is a power of two.
- `GROUND_Y`, 7'd110: first playfield row occupied by the ground.
- `FRAME_TICKS`, 833_333: clock cycles spent in WAIT per frame (60 Hz at 50 MHz).
- `COLOUR`, 3'b111: sprite colour.

- `clock` in 1: system clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low; returns the block to IDLE.
- `start` in 1: launch request; honoured only in IDLE and DONE.
- `spawn_x` in 8: launch column, sampled on start.
- `hit` in 1: one-cycle pulse from the rocket collision stage.
- `vga_x` out 8: pixel column to the VGA adapter.
- `vga_y` out 7: pixel row to the VGA adapter.
- `vga_colour` out 3: pixel colour.
- `vga_plot` out 1: write enable for the pixel.
- `asteroid_x` out 8: registered sprite position, column.
- `asteroid_y` out 7: registered sprite position, row.
- `active` out 1: asteroid is on screen (any state except IDLE and DONE).
- `asteroid_move_done` out 1: level; the sprite has reached the ground.

## Operation
- **State machine:** IDLE, DRAW, WAIT, ERASE, MOVE, DONE.
- **IDLE:**
  - On `start`, latch x = min(spawn_x, 160-SIZE) and set y = 0; next state is DRAW.
  - All other inputs are ignored.
- **DRAW:**
  - SIZE² cycles driven by a pixel counter `pc`.
  - vga_x = x + pc[low half], vga_y = y + pc[high half], vga_colour = COLOUR, vga_plot = 1.
  - When `pc` wraps: if y == GROUND_Y-SIZE go to DONE, else go to WAIT.
- **WAIT:**
  - Frame counter loads FRAME_TICKS-1 on entry and decrements each cycle.
  - At 0 the next state is ERASE.
- **ERASE:** identical to DRAW with vga_colour = 3'b000; next state is MOVE, or IDLE if the kill flag is set.
- **MOVE:** one cycle; y <= y + 1; next state is DRAW.
- **DONE:**
  - `asteroid_move_done` = 1 and the sprite stays drawn.
  - On `start`, clear `asteroid_move_done` and relaunch exactly as from IDLE.
- **Hit handling:**
  - A `hit` in any active state sets a sticky kill flag.
  - In WAIT, the kill flag forces ERASE at once, without waiting for the counter.
  - After ERASE, go to IDLE with `asteroid_move_done` = 0, then clear the kill flag.
  - A `hit` in IDLE or DONE is ignored.
- **Simultaneous events:**
  - `hit` and the frame-counter terminal count in the same cycle: hit wins; go to ERASE, then IDLE.
  - `start` while active is ignored.
- **Width rules:** x + pc and y + pc never exceed the screen because of the x clamp and the GROUND_Y limit; no wrap-around is permitted.
- **Reset values:** state = IDLE; x, y, pc, frame counter, kill flag = 0; vga_x, vga_y, vga_colour = 0; vga_plot, active, asteroid_move_done = 0.

## Timing
- **Launch:** the first `vga_plot` occurs in the cycle after the edge that samples `start`.
- **Frame period:** 2·SIZE² + FRAME_TICKS + 1 cycles.
- **Ground arrival:** `asteroid_move_done` rises (GROUND_Y-SIZE)·(frame period) + SIZE² + 1 cycles after the start edge.
- **Done output:**
  - `asteroid_move_done` is held until the next `start` or reset.
  - The downstream stage may therefore sample it at any cycle.
- **Hit latency:**
  - The erase completes at most frame period + SIZE² cycles after `hit`.
  - `active` falls in the cycle IDLE is entered.
- **Reset mid-operation:** all outputs go to 0 asynchronously, so `vga_plot` drops without waiting for a clock edge. A partially drawn sprite is left on screen; clearing it is the screen-clear block's job.
- **VGA outputs:** `vga_x`, `vga_y`, `vga_colour` and `vga_plot` are registered and mutually aligned.

## Structure
- **Shared package `asteroid_pkg`:**
  - State encoding.
  - Screen constants SCREEN_W = 160, SCREEN_H = 120.
  - Colour constants BLACK and WHITE.
  - GROUND_Y default.
  - These are shared with the collision and rocket stages.
- **Sub-module `frame_tick_counter`:**
  - Loadable down-counter parameterised by FRAME_TICKS.
  - Ports: clock, reset, load, en, tc.
- Everything else stays in one module: FSM, position registers and the pixel counter.

## Test plan
- **Launch and ground arrival:**
  - Setup: SIZE = 4, FRAME_TICKS = 4, GROUND_Y = 12; `start` with spawn_x = 20.
  - First 16 plots cover x 20–23, y 0–3, colour 7.
  - `asteroid_move_done` rises at cycle 313 after the start edge, with asteroid_y = 8.
- **Clamp:** spawn_x = 200 → asteroid_x = 156; the maximum vga_x is 159.
- **Hit in WAIT:**
  - `hit` during the first WAIT → 16 black plots at y 0–3.
  - Then IDLE and `active` = 0; `asteroid_move_done` is never asserted.
- **Hit timing corners:**
  - `hit` during DRAW → kill is deferred; the erase starts in the first WAIT cycle.
  - `hit` in the same cycle as the terminal count → the same result as a plain hit.
- **Reset and relaunch:**
  - Drop `reset` mid-DRAW → `vga_plot` = 0 immediately and all outputs are 0.
  - After release, a new `start` launches normally.
- **Restart from DONE:**
  - `start` in DONE clears `asteroid_move_done` in the next cycle.
  - asteroid_y = 0; the pixel sequence is identical to the first launch.

Source files
------------

// File: rtl/asteroid_pkg.sv
// asteroid_pkg: types and constants shared by the asteroid, rocket and
// collision stages (playfield geometry, colours, mover state encoding).
package asteroid_pkg;

    localparam int unsigned X_W = 8;
    localparam int unsigned Y_W = 7;
    localparam int unsigned C_W = 3;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;

    localparam logic [C_W-1:0] BLACK = 3'b000;
    localparam logic [C_W-1:0] WHITE = 3'b111;

    localparam logic [Y_W-1:0] GROUND_Y_DEFAULT = 7'd110;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRAW  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ERASE = 3'd3,
        ST_MOVE  = 3'd4,
        ST_DONE  = 3'd5
    } mover_state_e;

    // One pixel write towards the VGA adapter.
    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [C_W-1:0] colour;
        logic           plot;
    } vga_pixel_t;

    // Keeps a square sprite of edge `size` fully inside the playfield.
    function automatic logic [X_W-1:0] clamp_x(input logic [X_W-1:0] sx,
                                               input int unsigned   size);
        logic [X_W-1:0] lim;
        lim = X_W'(SCREEN_W - size);
        return (sx > lim) ? lim : sx;
    endfunction

endpackage

// File: rtl/asteroid_mover_if.sv
// asteroid_mover_if: launch/hit controls and VGA/position outputs of the
// asteroid mover.
//   master: drives start, spawn_x, hit; observes everything else
//   slave : the mover itself
interface asteroid_mover_if;
    import asteroid_pkg::*;

    logic           start;
    logic [X_W-1:0] spawn_x;
    logic           hit;
    logic [X_W-1:0] vga_x;
    logic [Y_W-1:0] vga_y;
    logic [C_W-1:0] vga_colour;
    logic           vga_plot;
    logic [X_W-1:0] asteroid_x;
    logic [Y_W-1:0] asteroid_y;
    logic           active;
    logic           asteroid_move_done;

    modport master (
        output start, spawn_x, hit,
        input  vga_x, vga_y, vga_colour, vga_plot,
        input  asteroid_x, asteroid_y, active, asteroid_move_done
    );

    modport slave (
        input  start, spawn_x, hit,
        output vga_x, vga_y, vga_colour, vga_plot,
        output asteroid_x, asteroid_y, active, asteroid_move_done
    );

endinterface

// File: rtl/frame_tick_counter.sv
// frame_tick_counter: loadable down-counter timing the pause between draw
// and erase. load presets FRAME_TICKS-1, en decrements (saturating at 0),
// tc is high while the count is 0.
//   clock, reset (async active-low), load, en -> tc
module frame_tick_counter #(
    parameter int unsigned FRAME_TICKS = 833_333
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic tc
);

    localparam int unsigned CNT_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

    logic [CNT_W-1:0] cnt_q;

    // Down-counter; load has priority over decrement.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= CNT_W'(FRAME_TICKS - 1);
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/asteroid_mover.sv
// asteroid_mover: drops one square sprite down the playfield a row per frame
// (draw, wait, erase, step) and holds asteroid_move_done once it rests on the
// ground. A rocket hit erases the sprite and returns to IDLE without done.
//   clock, reset (async active-low)
//   bus.start/spawn_x/hit            -> launch and kill controls
//   bus.vga_x/vga_y/vga_colour/plot  <- registered pixel writes
//   bus.asteroid_x/asteroid_y        <- registered sprite position
//   bus.active/asteroid_move_done    <- status
module asteroid_mover
    import asteroid_pkg::*;
#(
    parameter int unsigned    SIZE        = 4,
    parameter logic [Y_W-1:0] GROUND_Y    = GROUND_Y_DEFAULT,
    parameter int unsigned    FRAME_TICKS = 833_333,
    parameter logic [C_W-1:0] COLOUR      = WHITE
) (
    input logic             clock,
    input logic             reset,
    asteroid_mover_if.slave bus
);

    localparam int unsigned SIDE_W = $clog2(SIZE);
    localparam int unsigned PC_W   = 2 * SIDE_W;
    localparam logic [Y_W-1:0] LAND_Y = GROUND_Y - Y_W'(SIZE);

    mover_state_e    state_q, state_d;
    logic [X_W-1:0]  x_q, x_d;
    logic [Y_W-1:0]  y_q, y_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            kill_q, kill_d;
    vga_pixel_t      pix_q, pix_d;
    logic            done_q, done_d;
    logic            active_q, active_d;

    logic load_c, en_c, tc_c;
    logic kill_eff_c, pc_last_c;

    frame_tick_counter #(
        .FRAME_TICKS(FRAME_TICKS)
    ) u_frame_tick_counter (
        .clock(clock),
        .reset(reset),
        .load (load_c),
        .en   (en_c),
        .tc   (tc_c)
    );

    // State, position and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            pc_q     <= '0;
            kill_q   <= 1'b0;
            pix_q    <= '0;
            done_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            pc_q     <= pc_d;
            kill_q   <= kill_d;
            pix_q    <= pix_d;
            done_q   <= done_d;
            active_q <= active_d;
        end
    end

    // Next state plus next outputs; outputs are derived from the next-state
    // values so the pixel for pc lands in the same cycle the FSM sits on it.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        pc_d     = pc_q;
        kill_d   = kill_q;
        pix_d    = '0;
        done_d   = 1'b0;
        active_d = 1'b0;
        load_c   = 1'b0;
        en_c     = 1'b0;

        // A hit in the current cycle already counts as a kill.
        kill_eff_c = kill_q | bus.hit;
        pc_last_c  = &pc_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    x_d     = clamp_x(bus.spawn_x, SIZE);
                    y_d     = '0;
                    pc_d    = '0;
                    state_d = ST_DRAW;
                end
            end
            ST_DRAW: begin
                kill_d = kill_eff_c;
                pc_d   = pc_q + PC_W'(1);
                if (pc_last_c) begin
                    // A killed sprite is always erased, even on the last row.
                    state_d = (!kill_eff_c && (y_q == LAND_Y)) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                kill_d = kill_eff_c;
                en_c   = 1'b1;
                if (kill_eff_c || tc_c) begin
                    state_d = ST_ERASE;
                end
            end
            ST_ERASE: begin
                kill_d = kill_eff_c;
                pc_d   = pc_q + PC_W'(1);
                if (pc_last_c) begin
                    state_d = kill_eff_c ? ST_IDLE : ST_MOVE;
                end
            end
            ST_MOVE: begin
                kill_d  = kill_eff_c;
                y_d     = y_q + Y_W'(1);
                state_d = ST_DRAW;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_IDLE) begin
            kill_d = 1'b0;
        end

        load_c = (state_d == ST_WAIT) && (state_q != ST_WAIT);

        if ((state_d == ST_DRAW) || (state_d == ST_ERASE)) begin
            pix_d.plot   = 1'b1;
            pix_d.x      = x_d + X_W'(pc_d[SIDE_W-1:0]);
            pix_d.y      = y_d + Y_W'(pc_d[PC_W-1:SIDE_W]);
            pix_d.colour = (state_d == ST_DRAW) ? COLOUR : BLACK;
        end

        done_d   = (state_d == ST_DONE);
        active_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    end

    assign bus.vga_x              = pix_q.x;
    assign bus.vga_y              = pix_q.y;
    assign bus.vga_colour         = pix_q.colour;
    assign bus.vga_plot           = pix_q.plot;
    assign bus.asteroid_x         = x_q;
    assign bus.asteroid_y         = y_q;
    assign bus.active             = active_q;
    assign bus.asteroid_move_done = done_q;

endmodule

// File: tb/tb_asteroid_mover.sv
// Bench for asteroid_mover with a timeline model: the expected pixel, status
// and position for every cycle after a launch are computed from the frame
// schedule (draw SIZE^2, wait FRAME_TICKS, erase SIZE^2, move 1) and from
// where a hit lands inside that schedule.
module tb_asteroid_mover;
    import asteroid_pkg::*;

    localparam int SZ = 4;
    localparam int FT = 4;
    localparam logic [6:0] GY = 7'd12;
    localparam int PIX    = SZ * SZ;
    localparam int FP     = 2 * PIX + FT + 1;
    localparam int NF     = int'(GY) - SZ;
    localparam int DONE_K = NF * FP + PIX + 1;
    localparam int XMAX   = 160 - SZ;

    typedef struct {
        bit plot;
        int x;
        int y;
        int col;
        bit active;
        bit done;
        int ax;
        int ay;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   vectors;
    int   miscompares;
    int   max_vx;

    asteroid_mover_if bus();

    asteroid_mover #(
        .SIZE       (SZ),
        .GROUND_Y   (GY),
        .FRAME_TICKS(FT),
        .COLOUR     (3'b111)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // First cycle of the erase pass triggered by a hit seen in cycle hk.
    function automatic int erase_start(input int hk, output int ef);
        int f, r;
        f = (hk - 1) / FP;
        r = (hk - 1) % FP;
        if (r <= PIX) begin
            ef = f;
            return FP * f + 1 + PIX + 1;
        end else if (r < PIX + FT) begin
            ef = f;
            return FP * f + 1 + r + 1;
        end else if (r < 2 * PIX + FT) begin
            ef = f;
            return FP * f + 1 + PIX + FT;
        end
        ef = f + 1;
        return FP * (f + 1) + 1 + PIX + 1;
    endfunction

    // Expected outputs in cycle k (k = 1 is the cycle after the start edge).
    function automatic exp_t model(input int k, input int sx, input int hk);
        exp_t e;
        int   xc, f, r, ek, ef, i;
        xc = (sx > XMAX) ? XMAX : sx;
        e  = '{plot: 0, x: 0, y: 0, col: 0, active: 1, done: 0, ax: xc, ay: 0};
        if (hk > 0) begin
            ek = erase_start(hk, ef);
            if (k >= ek + PIX) begin
                e.active = 0;
                e.ay     = ef;
                return e;
            end else if (k >= ek) begin
                i      = k - ek;
                e.plot = 1;
                e.x    = xc + i % SZ;
                e.y    = ef + i / SZ;
                e.col  = 0;
                e.ay   = ef;
                return e;
            end
        end
        if (k >= DONE_K) begin
            e.active = 0;
            e.done   = 1;
            e.ay     = NF;
            return e;
        end
        f    = (k - 1) / FP;
        r    = (k - 1) % FP;
        e.ay = f;
        if (r < PIX) begin
            e.plot = 1;
            e.x    = xc + r % SZ;
            e.y    = f + r / SZ;
            e.col  = 7;
        end else if ((r >= PIX + FT) && (r < 2 * PIX + FT)) begin
            e.plot = 1;
            e.x    = xc + (r - PIX - FT) % SZ;
            e.y    = f + (r - PIX - FT) / SZ;
            e.col  = 0;
        end
        return e;
    endfunction

    // Launch from IDLE/DONE at a negedge; optional hit in cycle hk and an
    // ignored start (with a different spawn_x) in cycle stray_k.
    task automatic run_launch(input logic [7:0] sx, input int hk, input int stray_k);
        int   ncyc, ek, ef;
        exp_t e;
        max_vx = 0;
        if (hk > 0) begin
            ek   = erase_start(hk, ef);
            ncyc = ek + PIX + 2;
        end else begin
            ncyc = DONE_K + 3;
        end
        bus.spawn_x = sx;
        bus.start   = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clock);
            @(negedge clock);
            e = model(k, int'(sx), hk);
            chk($sformatf("plot sx=%0d hk=%0d k=%0d", sx, hk, k), 32'(bus.vga_plot), 32'(e.plot));
            chk($sformatf("active k=%0d", k), 32'(bus.active), 32'(e.active));
            chk($sformatf("done k=%0d", k), 32'(bus.asteroid_move_done), 32'(e.done));
            chk($sformatf("ast_x k=%0d", k), 32'(bus.asteroid_x), 32'(e.ax));
            chk($sformatf("ast_y k=%0d", k), 32'(bus.asteroid_y), 32'(e.ay));
            if (e.plot) begin
                chk($sformatf("vga_x k=%0d", k), 32'(bus.vga_x), 32'(e.x));
                chk($sformatf("vga_y k=%0d", k), 32'(bus.vga_y), 32'(e.y));
                chk($sformatf("colour k=%0d", k), 32'(bus.vga_colour), 32'(e.col));
            end
            if (bus.vga_plot && (int'(bus.vga_x) > max_vx)) max_vx = int'(bus.vga_x);
            bus.start   = (k == stray_k);
            bus.spawn_x = (k == stray_k) ? ~sx : sx;
            bus.hit     = (k == hk);
        end
        bus.start = 1'b0;
        bus.hit   = 1'b0;
    endtask

    initial begin
        logic [7:0] sx;
        int         hk;
        int         dir_hits[4];
        vectors     = 0;
        miscompares = 0;
        bus.start   = 1'b0;
        bus.hit     = 1'b0;
        bus.spawn_x = '0;
        dir_hits    = '{18, 5, 20, 37};

        // Reset state.
        repeat (2) @(negedge clock);
        chk("rst plot",   32'(bus.vga_plot), 0);
        chk("rst vga_x",  32'(bus.vga_x), 0);
        chk("rst vga_y",  32'(bus.vga_y), 0);
        chk("rst colour", 32'(bus.vga_colour), 0);
        chk("rst ast_x",  32'(bus.asteroid_x), 0);
        chk("rst ast_y",  32'(bus.asteroid_y), 0);
        chk("rst active", 32'(bus.active), 0);
        chk("rst done",   32'(bus.asteroid_move_done), 0);
        reset = 1'b1;
        @(negedge clock);

        // Launch to the ground.
        run_launch(8'd20, 0, 0);

        // Hit in DONE is ignored; done is held.
        bus.hit = 1'b1;
        @(negedge clock);
        bus.hit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("done held", 32'(bus.asteroid_move_done), 1);
            chk("done plot", 32'(bus.vga_plot), 0);
            chk("done active", 32'(bus.active), 0);
        end

        // Restart from DONE with a stray start while active.
        run_launch(8'd20, 0, 10);

        // Clamp plus hit during the first WAIT.
        run_launch(8'd200, 18, 0);
        chk("clamp max vga_x", 32'(max_vx), 159);

        // Hit in IDLE is ignored, then a plain launch.
        bus.hit = 1'b1;
        @(negedge clock);
        bus.hit = 1'b0;
        @(negedge clock);
        chk("idle hit active", 32'(bus.active), 0);

        // Directed hit corners: WAIT, DRAW, terminal count, MOVE.
        for (int i = 0; i < 4; i++) begin
            sx = 8'($urandom_range(0, 255));
            run_launch(sx, dir_hits[i], 0);
        end

        // Random spawn and hit points inside frames 0..NF-1.
        for (int i = 0; i < 6; i++) begin
            sx = 8'($urandom_range(0, 255));
            hk = int'($urandom_range(1, NF * FP - 1));
            run_launch(sx, hk, 0);
        end

        // Reset in the middle of DRAW drops everything asynchronously.
        bus.spawn_x = 8'd40;
        bus.start   = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        repeat (4) @(negedge clock);
        chk("mid draw plot", 32'(bus.vga_plot), 1);
        reset = 1'b0;
        #1;
        chk("async plot",   32'(bus.vga_plot), 0);
        chk("async vga_x",  32'(bus.vga_x), 0);
        chk("async vga_y",  32'(bus.vga_y), 0);
        chk("async colour", 32'(bus.vga_colour), 0);
        chk("async ast_x",  32'(bus.asteroid_x), 0);
        chk("async ast_y",  32'(bus.asteroid_y), 0);
        chk("async active", 32'(bus.active), 0);
        chk("async done",   32'(bus.asteroid_move_done), 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Relaunch after reset.
        sx = 8'($urandom_range(0, 255));
        run_launch(sx, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
